// File: rtl/countdown_timer_bank_if.sv
// Control/status bundle for the countdown timer bank: tick, per-channel
// load/mode/pause requests in, per-channel expiry/running/remaining out.
interface countdown_timer_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
);
    logic                      enable_1Hz;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] value;
    logic [CHANNELS-1:0]       auto_reload;
    logic [CHANNELS-1:0]       pause;
    logic [CHANNELS-1:0]       expired;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS*WIDTH-1:0] remaining;

    modport master (
        output enable_1Hz, load, value, auto_reload, pause,
        input  expired, running, remaining
    );

    modport slave (
        input  enable_1Hz, load, value, auto_reload, pause,
        output expired, running, remaining
    );
endinterface

// File: rtl/countdown_timer_bank.sv
// Bank of independent tick-driven countdown timers, each with one-shot or
// periodic reload, level-sensitive pause and a one-clock expiry pulse.
module countdown_timer_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  reset_sync,
    countdown_timer_bank_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t              state_q  [CHANNELS];
    state_t              state_n  [CHANNELS];
    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_n  [CHANNELS];
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_n [CHANNELS];
    logic [CHANNELS-1:0] expired_q;
    logic [CHANNELS-1:0] expired_n;
    logic [CHANNELS-1:0] running_q;
    logic [CHANNELS-1:0] running_n;
    logic [CHANNELS*WIDTH-1:0] remaining_flat;

    // State and output registers
    always_ff @(posedge clock or posedge reset_sync) begin
        if (reset_sync) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
            expired_q <= '0;
            running_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_n[i];
                count_q[i]  <= count_n[i];
                reload_q[i] <= reload_n[i];
            end
            expired_q <= expired_n;
            running_q <= running_n;
        end
    end

    // Per-channel next state; load wins over pause and tick in the same cycle
    always_comb begin
        expired_n = '0;
        running_n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_n[i]  = state_q[i];
            count_n[i]  = count_q[i];
            reload_n[i] = reload_q[i];
            if (bus.load[i]) begin
                if (bus.value[i*WIDTH +: WIDTH] == '0) begin
                    count_n[i]   = '0;
                    reload_n[i]  = '0;
                    state_n[i]   = ST_IDLE;
                    expired_n[i] = 1'b1;
                end else begin
                    count_n[i]  = bus.value[i*WIDTH +: WIDTH];
                    reload_n[i] = bus.value[i*WIDTH +: WIDTH];
                    state_n[i]  = bus.pause[i] ? ST_PAUSED : ST_RUN;
                end
            end else begin
                case (state_q[i])
                    ST_RUN: begin
                        if (bus.pause[i]) begin
                            state_n[i] = ST_PAUSED;
                        end else if (bus.enable_1Hz) begin
                            if (count_q[i] > WIDTH'(1)) begin
                                count_n[i] = count_q[i] - WIDTH'(1);
                            end else begin
                                // Terminal tick: the counter never goes below 1 while running
                                expired_n[i] = 1'b1;
                                if (bus.auto_reload[i]) begin
                                    count_n[i] = reload_q[i];
                                end else begin
                                    count_n[i] = '0;
                                    state_n[i] = ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!bus.pause[i]) begin
                            state_n[i] = ST_RUN;
                        end
                    end
                    default: begin
                        state_n[i] = ST_IDLE;
                    end
                endcase
            end
            running_n[i] = (state_n[i] != ST_IDLE);
        end
    end

    always_comb begin
        remaining_flat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            remaining_flat[i*WIDTH +: WIDTH] = count_q[i];
        end
    end

    assign bus.expired   = expired_q;
    assign bus.running   = running_q;
    assign bus.remaining = remaining_flat;
endmodule

// File: tb/tb_countdown_timer_bank.sv
// Self-checking bench for countdown_timer_bank: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_countdown_timer_bank;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned VW = CH * W;

    logic clock = 1'b0;
    logic reset_sync;

    always #5 clock = ~clock;

    countdown_timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    countdown_timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock      (clock),
        .reset_sync (reset_sync),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: count value, reload value, active flag, held flag
    int m_cnt  [CH];
    int m_rel  [CH];
    bit m_act  [CH];
    bit m_hold [CH];
    bit m_exp  [CH];
    int pulses [CH];

    typedef struct {
        logic [CH-1:0] load;
        logic [VW-1:0] value;
        logic [CH-1:0] ar;
        logic [CH-1:0] pause;
        logic          tick;
        logic [CH-1:0] e_exp;
        logic [CH-1:0] e_run;
        logic [VW-1:0] e_rem;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_act[i] = 0; m_hold[i] = 0; m_exp[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (reset_sync) begin
            model_zero();
            return;
        end
        for (int i = 0; i < CH; i++) begin
            int v;
            v = int'(bus.value[i*W +: W]);
            m_exp[i] = 0;
            if (bus.load[i]) begin
                if (v == 0) begin
                    m_cnt[i] = 0; m_rel[i] = 0; m_act[i] = 0; m_exp[i] = 1;
                end else begin
                    m_cnt[i] = v; m_rel[i] = v; m_act[i] = 1; m_hold[i] = bus.pause[i];
                end
            end else if (m_act[i]) begin
                if (m_hold[i]) begin
                    m_hold[i] = bus.pause[i];
                end else if (bus.pause[i]) begin
                    m_hold[i] = 1;
                end else if (bus.enable_1Hz) begin
                    if (m_cnt[i] > 1) begin
                        m_cnt[i]--;
                    end else begin
                        m_exp[i] = 1;
                        if (bus.auto_reload[i]) begin
                            m_cnt[i] = m_rel[i];
                        end else begin
                            m_cnt[i] = 0;
                            m_act[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_rem();
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_vec(input bit sel_exp);
        logic [CH-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i] = sel_exp ? m_exp[i] : m_act[i];
        return r;
    endfunction

    // One clock: advance the model at the edge, compare just after it
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("model_expired", VW'(bus.expired), VW'(exp_vec(1'b1)));
        chk("model_running", VW'(bus.running), VW'(exp_vec(1'b0)));
        chk("model_remaining", bus.remaining, exp_rem());
        for (int i = 0; i < CH; i++) if (bus.expired[i]) pulses[i]++;
    endtask

    task automatic tick_after(input int gap);
        repeat (gap - 1) step();
        bus.enable_1Hz = 1'b1;
        step();
        bus.enable_1Hz = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.enable_1Hz = 1'b0; bus.load = '0; bus.value = '0;
        bus.auto_reload = '0; bus.pause = '0;
    endtask

    task automatic do_reset();
        reset_sync = 1'b1;
        model_zero();
        #1;
        chk("reset_expired", VW'(bus.expired), '0);
        chk("reset_running", VW'(bus.running), '0);
        chk("reset_remaining", bus.remaining, '0);
        step();
        reset_sync = 1'b0;
        for (int i = 0; i < CH; i++) pulses[i] = 0;
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 32'h0200_0000, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b1000, 32'h0200_0000};
        tbl[1]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b1000, 32'h0100_0000};
        tbl[2]  = '{4'b1000, 32'h0400_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b1000, 32'h0400_0000};
        tbl[3]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b1000, 1'b1, 4'b0000, 4'b1000, 32'h0400_0000};
        tbl[4]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b1000, 1'b1, 4'b0000, 4'b1000, 32'h0400_0000};
        tbl[5]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b1000, 32'h0400_0000};
        tbl[6]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b1000, 32'h0300_0000};
        tbl[7]  = '{4'b1000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b1000, 4'b0000, 32'h0000_0000};
        tbl[8]  = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000};
        tbl[9]  = '{4'b0001, 32'h0000_0001, 4'b0010, 4'b0001, 1'b1, 4'b0000, 4'b0001, 32'h0000_0001};
        tbl[10] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0001, 32'h0000_0001};
        tbl[11] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0000, 32'h0000_0000};
        tbl[12] = '{4'b0010, 32'h0000_0100, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 32'h0000_0100};
        tbl[13] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 32'h0000_0100};
        tbl[14] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 32'h0000_0100};
        tbl[15] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 32'h0000_0100};
        tbl[16] = '{4'b0100, 32'h00FF_0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0110, 32'h00FF_0100};

        clear_inputs();
        do_reset();
        step();

        // Vector table: one row per clock
        for (int r = 0; r < 17; r++) begin
            bus.load = tbl[r].load; bus.value = tbl[r].value; bus.auto_reload = tbl[r].ar;
            bus.pause = tbl[r].pause; bus.enable_1Hz = tbl[r].tick;
            step();
            chk($sformatf("tbl%0d_expired", r), VW'(bus.expired), VW'(tbl[r].e_exp));
            chk($sformatf("tbl%0d_running", r), VW'(bus.running), VW'(tbl[r].e_run));
            chk($sformatf("tbl%0d_remaining", r), bus.remaining, tbl[r].e_rem);
        end
        clear_inputs();

        // One-shot ch0 = 3, ticks every 10 clocks
        do_reset();
        bus.load = 4'b0001; bus.value = 32'h0000_0003;
        step();
        bus.load = '0;
        chk("seq_oneshot_load", VW'(bus.remaining[7:0]), VW'(3));
        for (int k = 1; k <= 3; k++) begin
            tick_after(10);
            chk("seq_oneshot_rem", VW'(bus.remaining[7:0]), VW'(3 - k));
            chk("seq_oneshot_exp", VW'(bus.expired[0]), VW'(k == 3));
            chk("seq_oneshot_run", VW'(bus.running[0]), VW'(k != 3));
        end
        step();
        chk("seq_oneshot_pulse_width", VW'(bus.expired[0]), '0);

        // Periodic ch1 = 2 over 6 ticks
        bus.auto_reload = 4'b0010; bus.load = 4'b0010; bus.value = 32'h0000_0200;
        step();
        bus.load = '0;
        for (int k = 0; k < 6; k++) tick_after(10);
        step();
        chk("seq_periodic_pulses", VW'(pulses[1]), VW'(3));
        chk("seq_periodic_run", VW'(bus.running[1]), VW'(1));
        chk("seq_periodic_rem", VW'(bus.remaining[15:8]), VW'(2));

        // Pause ch2 = 5 for 4 ticks after 2 ticks
        bus.load = 4'b0100; bus.value = 32'h0005_0000;
        step();
        bus.load = '0;
        tick_after(10); tick_after(10);
        bus.pause = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick_after(10);
            chk("seq_pause_hold", VW'(bus.remaining[23:16]), VW'(3));
        end
        bus.pause = '0;
        tick_after(10); tick_after(10);
        chk("seq_pause_early", VW'(pulses[2]), '0);
        tick_after(10);
        chk("seq_pause_expiry", VW'(pulses[2]), VW'(1));
        chk("seq_pause_idle", VW'(bus.running[2]), '0);

        // Asynchronous reset mid-count
        bus.auto_reload = '0;
        for (int i = 0; i < CH; i++) pulses[i] = 0;
        bus.load = 4'b0001; bus.value = 32'h0000_0004;
        step();
        bus.load = '0;
        tick_after(10); tick_after(10);
        chk("seq_reset_pre", VW'(bus.remaining[7:0]), VW'(2));
        #2;
        do_reset();
        for (int k = 0; k < 3; k++) tick_after(10);
        chk("seq_reset_no_pulse", VW'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), '0);
        chk("seq_reset_rem", bus.remaining, '0);
        chk("seq_reset_run", VW'(bus.running), '0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            bus.enable_1Hz = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < CH; i++) begin
                bus.load[i] = ($urandom_range(0, 9) == 0);
                bus.value[i*W +: W] = W'($urandom_range(0, 5));
                if ($urandom_range(0, 7) == 0) bus.pause[i] = ~bus.pause[i];
                if ($urandom_range(0, 15) == 0) bus.auto_reload[i] = ~bus.auto_reload[i];
            end
            if ($urandom_range(0, 399) == 0) begin
                reset_sync = 1'b1;
                model_zero();
            end else begin
                reset_sync = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
